rvr32_lsa_np: RTL and testbench
===============================

RVR32_LSA_NP -- requirements
Module: rvr32_lsa_np

Interface
REQ-001 Parameter NPORT, default 4, number of requester ports; legal range 2..16.
REQ-002 Parameter DW, default 32, data width; legal values are multiples of 8.
REQ-003 Parameter AW, default 32, address width.
REQ-004 Parameter TMO, default 255, watchdog limit in BUSY cycles; 0 disables the watchdog.
REQ-005 Derived localparam SW = DW/8 (strobe width); IW = clog2(NPORT) (index width).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 valid  in  NPORT  per-port request; bit i belongs to port i.
REQ-009 addr  in  NPORT*AW  flat address bus; port i occupies bits [i*AW +: AW].
REQ-010 wdata  in  NPORT*DW  flat write data; port i occupies [i*DW +: DW].
REQ-011 wstrb  in  NPORT*SW  flat byte strobes; all-zero means read.
REQ-012 ready  out  NPORT  per-port completion, one-hot or zero.
REQ-013 rdata  out  DW  read data, broadcast to all ports.
REQ-014 mem_valid  out  1  memory request.
REQ-015 mem_addr, mem_wdata, mem_wstrb  out  AW, DW, SW  request payload of the granted port.
REQ-016 mem_ready  in  1  memory completion; mem_rdata is valid in the same cycle.
REQ-017 mem_rdata  in  DW  memory read data.
REQ-018 gnt_idx  out  IW  index of the currently granted port.
REQ-019 busy  out  1  high while in BUSY.
REQ-020 tmo_err  out  1  one-cycle pulse on a watchdog expiry.

Function
REQ-021 FSM states: IDLE and BUSY.
REQ-022 IDLE with any valid bit set: latch gnt_idx to the first set bit searching ptr, ptr+1, ..., wrapping modulo NPORT; enter BUSY next cycle. Arbitration latency is one cycle.
REQ-023 IDLE with no valid bits set: stay in IDLE; ptr is unchanged.
REQ-024 BUSY: mem_valid = valid[gnt_idx]; payload = port gnt_idx slice; ready[gnt_idx] = mem_ready & valid[gnt_idx]; all other ready bits are 0.
REQ-025 In IDLE, mem_valid, mem_addr, mem_wdata and mem_wstrb are driven to 0.
REQ-026 rdata = mem_rdata combinationally, in every state.
REQ-027 BUSY with mem_ready & valid[gnt_idx]: next state IDLE; ptr <= (gnt_idx+1) mod NPORT. The wrap applies when NPORT is not a power of 2.
REQ-028 BUSY with valid[gnt_idx] low (requester abort): next state IDLE; ptr is unchanged; no ready is issued.
REQ-029 gnt_idx is stable for the whole of BUSY; valid changes on other ports have no effect until the state returns to IDLE.
REQ-030 Back-to-back: the minimum gap between consecutive transactions is one IDLE cycle. Per-port throughput is therefore at most one transfer per 2 cycles.
REQ-031 Watchdog:
- Counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
- If TMO != 0 and the counter reaches TMO: pulse tmo_err for 1 cycle, return to IDLE, and set ptr <= gnt_idx+1 mod NPORT.
- No ready is issued on a timeout.
REQ-032 mem_ready received in IDLE is ignored.
REQ-033 Fairness: any port that holds valid is granted within NPORT arbitration rounds.

Reset
REQ-034 rst_n low asynchronously forces: state IDLE, ptr 0, gnt_idx 0, watchdog counter 0, busy 0, tmo_err 0.
REQ-035 During reset: mem_valid is 0, ready is all 0, and the payload outputs are 0.
REQ-036 Reset asserted mid-BUSY abandons the transaction with no ready pulse.
REQ-037 After reset release, the first arbitration occurs on the first rising edge at which any valid bit is set.

Verification
REQ-038 Single request, NPORT=4: valid=0100, addr2=0x1000, mem_ready high on the 2nd BUSY cycle -> mem_addr=0x1000; ready=0100 for exactly 1 cycle; ptr=3.
REQ-039 All ports request continuously, mem_ready always 1 -> grant order 0,1,2,3,0; one IDLE cycle between each grant.
REQ-040 NPORT=3, valid=111 -> grant order 0,1,2,0; confirms wrap at a non-power-of-2 port count.
REQ-041 TMO=4, port 1 granted, mem_ready held 0 -> tmo_err pulses at the 4th BUSY cycle; state IDLE; ready never asserted; next grant goes to port 2 if it is requesting.
REQ-042 Port 0 in BUSY drops valid before mem_ready -> mem_valid falls in the same cycle; IDLE next cycle; ptr stays 0.
REQ-043 rst_n pulsed low mid-BUSY -> mem_valid and ready go 0 immediately; after release, the grant search starts from port 0.

Source files
------------

// File: rtl/rvr32_lsa_np.sv
// rvr32_lsa_np: round-robin load/store arbiter.
// NPORT requesters share one memory port; one transaction is in flight at a
// time. A grant is latched in IDLE, held for the whole of BUSY, and released
// on completion, on requester abort, or on watchdog expiry.
module rvr32_lsa_np #(
    parameter int NPORT = 4,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int TMO   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPORT-1:0]      valid,
    input  logic [NPORT*AW-1:0]   addr,
    input  logic [NPORT*DW-1:0]   wdata,
    input  logic [NPORT*DW/8-1:0] wstrb,
    output logic [NPORT-1:0]      ready,
    output logic [DW-1:0]         rdata,
    output logic                  mem_valid,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic [DW/8-1:0]       mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DW-1:0]         mem_rdata,
    output logic [((NPORT > 1) ? $clog2(NPORT) : 1)-1:0] gnt_idx,
    output logic                  busy,
    output logic                  tmo_err
);

    localparam int SW = DW / 8;
    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    // Counter only needs to hold values up to TMO-1 before it fires.
    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = (TMO > 0) ? TW'(TMO - 1) : '0;
    localparam logic [IW-1:0] LAST_PORT = IW'(NPORT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            gnt_vld;
    logic            tmo_fire;

    // First requesting port at or after 'start', wrapping modulo NPORT.
    // Iterating from the far end lets the nearest candidate overwrite the rest.
    function automatic logic [IW-1:0] rr_pick(input logic [NPORT-1:0] req,
                                              input logic [IW-1:0]    start);
        logic [IW-1:0] sel;
        int            j;
        sel = start;
        for (int k = NPORT - 1; k >= 0; k--) begin
            j = (int'(start) + k) % NPORT;
            if (req[j]) begin
                sel = j[IW-1:0];
            end
        end
        return sel;
    endfunction

    // Successor port index; explicit wrap so non-power-of-2 counts work.
    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
        return (i == LAST_PORT) ? '0 : i + 1'b1;
    endfunction

    assign gnt_vld = valid[gnt_q];

    // Next-state logic: arbitration in IDLE, completion/abort/watchdog in BUSY.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        tmo_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (|valid) begin
                    gnt_d   = rr_pick(valid, ptr_q);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!gnt_vld) begin
                    // Requester withdrew: drop the grant, keep the search origin.
                    state_d = IDLE;
                end else if (mem_ready) begin
                    state_d = IDLE;
                    ptr_d   = inc_wrap(gnt_q);
                end else if (TMO != 0) begin
                    if (cnt_q == TMO_LAST) begin
                        // Stalled slave: give up and move the search past this port.
                        tmo_fire = 1'b1;
                        state_d  = IDLE;
                        ptr_d    = inc_wrap(gnt_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, grant and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory-side request and per-port completion; everything quiet outside BUSY.
    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        ready     = '0;
        if (state_q == BUSY) begin
            mem_valid    = gnt_vld;
            mem_addr     = addr[int'(gnt_q) * AW +: AW];
            mem_wdata    = wdata[int'(gnt_q) * DW +: DW];
            mem_wstrb    = wstrb[int'(gnt_q) * SW +: SW];
            ready[gnt_q] = mem_ready & gnt_vld;
        end
    end

    assign rdata   = mem_rdata;
    assign gnt_idx = gnt_q;
    assign busy    = (state_q == BUSY);
    assign tmo_err = tmo_fire;

endmodule

// File: tb/tb_rvr32_lsa_np.sv
// Bench for rvr32_lsa_np: a 4-port instance (TMO=4) driven from a vector
// table plus a round-robin scoreboard, and a 3-port instance for wrap order.
module tb_rvr32_lsa_np;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    // 4-port DUT signals
    logic [3:0]   valid;
    logic [127:0] addr;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic [3:0]   ready;
    logic [31:0]  rdata;
    logic         mem_valid;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         mem_ready;
    logic [31:0]  mem_rdata;
    logic [1:0]   gnt_idx;
    logic         busy;
    logic         tmo_err;
    // 3-port DUT signals
    logic [2:0]   v3_valid;
    logic [95:0]  v3_addr;
    logic [95:0]  v3_wdata;
    logic [11:0]  v3_wstrb;
    logic [2:0]   v3_ready;
    logic [31:0]  v3_rdata;
    logic         v3_mem_valid;
    logic [31:0]  v3_mem_addr;
    logic [31:0]  v3_mem_wdata;
    logic [3:0]   v3_mem_wstrb;
    logic         v3_mem_ready;
    logic [31:0]  v3_mem_rdata;
    logic [1:0]   v3_gnt_idx;
    logic         v3_busy;
    logic         v3_tmo_err;

    rvr32_lsa_np #(.NPORT(4), .DW(32), .AW(32), .TMO(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .ready(ready), .rdata(rdata), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .gnt_idx(gnt_idx),
        .busy(busy), .tmo_err(tmo_err)
    );

    rvr32_lsa_np #(.NPORT(3), .DW(32), .AW(32), .TMO(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .valid(v3_valid), .addr(v3_addr), .wdata(v3_wdata),
        .wstrb(v3_wstrb), .ready(v3_ready), .rdata(v3_rdata), .mem_valid(v3_mem_valid),
        .mem_addr(v3_mem_addr), .mem_wdata(v3_mem_wdata), .mem_wstrb(v3_mem_wstrb),
        .mem_ready(v3_mem_ready), .mem_rdata(v3_mem_rdata), .gnt_idx(v3_gnt_idx),
        .busy(v3_busy), .tmo_err(v3_tmo_err)
    );

    // Per-port payload constants (port 2 carries the 0x1000 address).
    logic [31:0] pa [4] = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_1000, 32'h0000_00A3};
    logic [31:0] pd [4] = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    logic [3:0]  ps [4] = '{4'h0, 4'h1, 4'hF, 4'h8};

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic       mr;
        logic       eb;     // expected busy
        logic       emv;    // expected mem_valid
        logic [3:0] er;     // expected ready
        logic [1:0] eg;     // expected gnt_idx
        logic       et;     // expected tmo_err
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic mr,
                       input logic eb, input logic emv, input logic [3:0] er,
                       input logic [1:0] eg, input logic et);
        vec_t t;
        t.rst_n = r; t.valid = v; t.mr = mr; t.eb = eb; t.emv = emv;
        t.er = er; t.eg = eg; t.et = et;
        tbl.push_back(t);
    endtask

    task automatic apply(input int idx);
        vec_t t;
        string tag;
        t = tbl[idx];
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        rst_n     = t.rst_n;
        valid     = t.valid;
        mem_ready = t.mr;
        mem_rdata = $urandom;
        #1;
        chk({tag, ".busy"},  busy,      t.eb);
        chk({tag, ".mvld"},  mem_valid, t.emv);
        chk({tag, ".ready"}, ready,     t.er);
        chk({tag, ".gnt"},   gnt_idx,   t.eg);
        chk({tag, ".tmo"},   tmo_err,   t.et);
        chk({tag, ".addr"},  mem_addr,  t.eb ? pa[t.eg] : 32'h0);
        chk({tag, ".wdata"}, mem_wdata, t.eb ? pd[t.eg] : 32'h0);
        chk({tag, ".wstrb"}, mem_wstrb, t.eb ? ps[t.eg] : 4'h0);
        chk({tag, ".rdata"}, rdata,     mem_rdata);
    endtask

    initial begin
        int exp_q[$];
        int last_c;
        int g;

        // Single request to port 2, completion on 2nd BUSY cycle, then ptr=3 probe
        add(1, 4'b0100, 0, 0, 0, 4'b0000, 0, 0);
        add(1, 4'b0100, 0, 1, 1, 4'b0000, 2, 0);
        add(1, 4'b0100, 1, 1, 1, 4'b0100, 2, 0);
        add(1, 4'b0000, 1, 0, 0, 4'b0000, 2, 0);   // mem_ready in IDLE ignored
        add(1, 4'b1111, 0, 0, 0, 4'b0000, 2, 0);
        add(1, 4'b1111, 1, 1, 1, 4'b1000, 3, 0);   // search starts at 3
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 3, 0);
        // Watchdog: port 1 granted (ptr=1), port 2 also requesting, no mem_ready
        add(1, 4'b0110, 0, 0, 0, 4'b0000, 0, 0);
        add(1, 4'b0110, 0, 1, 1, 4'b0000, 1, 0);
        add(1, 4'b0110, 0, 1, 1, 4'b0000, 1, 0);
        add(1, 4'b0110, 0, 1, 1, 4'b0000, 1, 0);
        add(1, 4'b0110, 0, 1, 1, 4'b0000, 1, 1);   // 4th BUSY cycle
        add(1, 4'b0110, 0, 0, 0, 4'b0000, 1, 0);
        add(1, 4'b0110, 1, 1, 1, 4'b0100, 2, 0);   // next grant is port 2
        // Abort: port 0 granted from ptr=3, then drops valid
        add(1, 4'b0001, 0, 0, 0, 4'b0000, 2, 0);
        add(1, 4'b0001, 0, 1, 1, 4'b0000, 0, 0);
        add(1, 4'b0000, 1, 1, 0, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
        add(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0);
        add(1, 4'b1111, 1, 1, 1, 4'b1000, 3, 0);   // ptr unchanged at 3
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 3, 0);
        // Reset mid-BUSY: move ptr to 3, grant port 1, then pulse reset
        add(1, 4'b0100, 0, 0, 0, 4'b0000, 3, 0);
        add(1, 4'b0100, 1, 1, 1, 4'b0100, 2, 0);
        add(1, 4'b0010, 0, 0, 0, 4'b0000, 2, 0);
        add(1, 4'b0010, 0, 1, 1, 4'b0000, 1, 0);
        add(0, 4'b0010, 1, 0, 0, 4'b0000, 0, 0);   // async reset drops everything
        add(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0);
        add(1, 4'b1111, 1, 1, 1, 4'b0001, 0, 0);   // search restarts at port 0
        add(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);

        rst_n = 1'b0; valid = 4'b1111; mem_ready = 1'b1; mem_rdata = '0;
        addr  = {pa[3], pa[2], pa[1], pa[0]};
        wdata = {pd[3], pd[2], pd[1], pd[0]};
        wstrb = {ps[3], ps[2], ps[1], ps[0]};
        v3_valid = '0; v3_mem_ready = 1'b0; v3_mem_rdata = '0;
        v3_addr = {32'hC2, 32'hC1, 32'hC0}; v3_wdata = '0; v3_wstrb = '0;

        // Outputs held quiet while in reset even with requests present
        @(negedge clk); #1;
        chk("rst.busy", busy, 1'b0);
        chk("rst.mvld", mem_valid, 1'b0);
        chk("rst.ready", ready, 4'b0);
        chk("rst.gnt", gnt_idx, 2'd0);
        chk("rst.tmo", tmo_err, 1'b0);
        chk("rst.addr", mem_addr, 32'h0);

        @(negedge clk);
        rst_n = 1'b1; valid = 4'b0000; mem_ready = 1'b0;
        #1;
        chk("post_rst.busy", busy, 1'b0);

        for (int i = 0; i < 7; i++) apply(i);

        // Scoreboard: all ports requesting, memory always ready
        exp_q = {0, 1, 2, 3, 0};
        last_c = -1;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            valid = 4'b1111; mem_ready = 1'b1; mem_rdata = $urandom;
            #1;
            if (ready != 4'b0) begin
                g = exp_q.pop_front();
                chk("rr.gnt", gnt_idx, g);
                chk("rr.ready", ready, 4'b1 << g);
                chk("rr.addr", mem_addr, pa[g]);
                if (last_c >= 0) chk("rr.gap", c - last_c, 2);
                last_c = c;
            end
        end
        chk("rr.drained", exp_q.size(), 0);

        for (int i = 7; i < tbl.size(); i++) apply(i);

        // Three ports: grant order must wrap 2 -> 0
        exp_q = {0, 1, 2, 0};
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            v3_valid = 3'b111; v3_mem_ready = 1'b1;
            #1;
            if (v3_ready != 3'b0) begin
                g = exp_q.pop_front();
                chk("np3.gnt", v3_gnt_idx, g);
                chk("np3.ready", v3_ready, 3'b1 << g);
                chk("np3.addr", v3_mem_addr, 32'hC0 + g);
            end
        end
        chk("np3.drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
